timer60_bcd_counter: RTL and testbench

Seconds-counting core of the 60-second timer. Divides the system clock down to a 1 Hz tick, accumulates elapsed seconds as two BCD digits, and applies start/stop/clear control through a small state machine. Its `onesDigit` and `tensDigit` outputs feed the BCD-to-one-hot LED decoder stage directly downstream, one decoder per digit.

---
 rtl/timer60_pkg.sv | 33 +++
 rtl/timer60_bcd_counter_prescaler.sv | 33 +++
 rtl/timer60_bcd_counter.sv | 152 +++++++++++++++
 tb/tb_timer60_bcd_counter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer60_pkg.sv
// timer60_pkg: shared types and constants for the 60-second BCD timer.
// Optional feature macro used by the timer: TIMER60_WRAP_EN.
package timer60_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } timer_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT       = 4'd9;
    localparam int         TIMER60_DEFAULT_MAX = 59;

    // Advance a two-digit BCD value by one second.
    function automatic logic [7:0] bcd_inc(input bcd_digit_t tens,
                                           input bcd_digit_t ones);
        bcd_digit_t t;
        bcd_digit_t o;
        t = tens;
        o = ones;
        if (o == BCD_MAX_DIGIT) begin
            o = 4'd0;
            t = t + 4'd1;
        end else begin
            o = o + 4'd1;
        end
        return {t, o};
    endfunction

endpackage

// File: rtl/timer60_bcd_counter_prescaler.sv
// tick_prescaler: divides the system clock down to one pulse per DIV cycles.
// Count holds while disabled; zero forces it back to 0.
module tick_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic zero,
    output logic tick_next
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick_next = enable && (cnt == LAST);

    // Count cycles while enabled, wrapping after the last one.
    always_ff @(posedge clk) begin
        if (reset || zero) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/timer60_bcd_counter.sv
// timer60_bcd_counter: 1 Hz BCD seconds counter with start/stop/clear.
// Define TIMER60_WRAP_EN to wrap at the terminal count instead of stopping.
module timer60_bcd_counter
    import timer60_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_HZ     = 1,
    parameter int MAX_SECONDS = TIMER60_DEFAULT_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output bcd_digit_t onesDigit,
    output bcd_digit_t tensDigit,
    output logic       tick,
    output logic       running,
    output logic       done
);

    localparam int DIV = CLK_HZ / TICK_HZ;

    localparam bcd_digit_t MAX_ONES = 4'(MAX_SECONDS % 10);
    localparam bcd_digit_t MAX_TENS = 4'(MAX_SECONDS / 10);

    if (DIV < 2) begin : g_div_chk
        $error("timer60_bcd_counter: CLK_HZ/TICK_HZ must be >= 2");
    end

    if (MAX_SECONDS < 1 || MAX_SECONDS > 99) begin : g_max_chk
        $error("timer60_bcd_counter: MAX_SECONDS must be in 1..99");
    end

    timer_state_t state;
    timer_state_t state_n;

    logic pre_en;
    logic pre_zero;
    logic tick_next;
    logic adv;
    logic at_max;
    logic [7:0] inc_val;

    assign at_max  = (onesDigit == MAX_ONES) && (tensDigit == MAX_TENS);
    assign inc_val = bcd_inc(tensDigit, ones_digit_w());

    function automatic bcd_digit_t ones_digit_w();
        return onesDigit;
    endfunction

    tick_prescaler #(
        .DIV(DIV)
    ) u_pre (
        .clk      (clk),
        .reset    (reset),
        .enable   (pre_en),
        .zero     (pre_zero),
        .tick_next(tick_next)
    );

    // Command decode with clear > stop > start priority.
    always_comb begin
        state_n  = state;
        pre_en   = 1'b0;
        pre_zero = 1'b0;
        adv      = 1'b0;
        priority case (1'b1)
            clear: begin
                state_n  = IDLE;
                pre_zero = 1'b1;
            end
            stop: begin
                if (state == RUN) begin
                    state_n = PAUSE;
                end
            end
            start: begin
                if (state == IDLE) begin
                    state_n  = RUN;
                    pre_zero = 1'b1;
                end else if (state == PAUSE) begin
                    state_n = RUN;
                end
            end
            default: begin
                state_n = state;
            end
        endcase
        if (state == RUN && !clear && !stop) begin
            pre_en = 1'b1;
            adv    = tick_next;
`ifndef TIMER60_WRAP_EN
            if (tick_next && at_max) begin
                state_n = DONE;
            end
`endif
        end
    end

    // State register and registered running flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_n;
            running <= (state_n == RUN);
        end
    end

    // BCD digit update on each prescaler wrap.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            onesDigit <= '0;
            tensDigit <= '0;
        end else if (adv) begin
            if (!at_max) begin
                tensDigit <= inc_val[7:4];
                onesDigit <= inc_val[3:0];
            end else begin
`ifdef TIMER60_WRAP_EN
                onesDigit <= '0;
                tensDigit <= '0;
`else
                onesDigit <= onesDigit;
                tensDigit <= tensDigit;
`endif
            end
        end
    end

    // Tick pulse and terminal-count indication.
    always_ff @(posedge clk) begin
        if (reset) begin
            tick <= 1'b0;
            done <= 1'b0;
        end else begin
            tick <= adv;
`ifdef TIMER60_WRAP_EN
            done <= adv && at_max;
`else
            if (clear) begin
                done <= 1'b0;
            end else if (adv && at_max) begin
                done <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_timer60_bcd_counter.sv
// tb_timer60_bcd_counter: scoreboard bench against a seconds-level model.
// Follows TIMER60_WRAP_EN the same way the design does.
module tb_timer60_bcd_counter;

    localparam int DIV  = 10;
    localparam int MAXS = 59;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    typedef struct {
        bit [3:0] ones;
        bit [3:0] tens;
        bit       tk;
        bit       run;
        bit       dn;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] onesDigit;
    logic [3:0] tensDigit;
    logic       tick;
    logic       running;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    int mode = M_IDLE;
    int secs = 0;
    int phase = 0;
    bit m_tick = 1'b0;
    bit m_done = 1'b0;

    exp_t stat_q[$];
    exp_t tick_q[$];

    always #5 clk = ~clk;

    timer60_bcd_counter #(
        .CLK_HZ     (10),
        .TICK_HZ    (1),
        .MAX_SECONDS(MAXS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .onesDigit(onesDigit),
        .tensDigit(tensDigit),
        .tick     (tick),
        .running  (running),
        .done     (done)
    );

    function automatic void chk(string nm, int act, int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     nm, act, exp_v, $time);
        end
    endfunction

    // Elapsed-seconds model: one second per DIV running cycles.
    function automatic void model(bit r, bit c, bit p, bit s);
        m_tick = 1'b0;
`ifdef TIMER60_WRAP_EN
        m_done = 1'b0;
`endif
        if (r || c) begin
            mode   = M_IDLE;
            secs   = 0;
            phase  = 0;
            m_done = 1'b0;
        end else if (mode == M_RUN && p) begin
            mode = M_PAUSE;
        end else if (mode == M_RUN) begin
            phase++;
            if (phase == DIV) begin
                phase  = 0;
                m_tick = 1'b1;
                if (secs == MAXS) begin
`ifdef TIMER60_WRAP_EN
                    secs   = 0;
                    m_done = 1'b1;
`else
                    mode   = M_DONE;
                    m_done = 1'b1;
`endif
                end else begin
                    secs++;
                end
            end
        end else if (!p && s && mode == M_IDLE) begin
            mode  = M_RUN;
            phase = 0;
        end else if (!p && s && mode == M_PAUSE) begin
            mode = M_RUN;
        end
    endfunction

    task automatic step(input bit r, input bit c, input bit p, input bit s);
        exp_t e;
        reset = r;
        clear = c;
        stop  = p;
        start = s;
        @(posedge clk);
        model(r, c, p, s);
        e.ones = 4'(secs % 10);
        e.tens = 4'(secs / 10);
        e.tk   = m_tick;
        e.run  = (mode == M_RUN);
        e.dn   = m_done;
        stat_q.push_back(e);
        if (m_tick) tick_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    // Per-cycle status check and per-tick event check.
    always @(negedge clk) begin
        exp_t e;
        exp_t t;
        if (stat_q.size() > 0) begin
            e = stat_q.pop_front();
            chk("ones", int'(onesDigit), int'(e.ones));
            chk("tens", int'(tensDigit), int'(e.tens));
            chk("tick", int'(tick), int'(e.tk));
            chk("running", int'(running), int'(e.run));
            chk("done", int'(done), int'(e.dn));
            n_cmp++;
            if (onesDigit > 4'd9 || tensDigit > 4'd9) begin
                n_bad++;
                $display("FAIL bcd_range: got %0d%0d, required digits <= 9",
                         tensDigit, onesDigit);
            end
            if (tick === 1'b1) begin
                if (tick_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL tick_event: got unexpected tick, expected none");
                end else begin
                    t = tick_q.pop_front();
                    chk("tick_secs", int'(tensDigit) * 10 + int'(onesDigit),
                        int'(t.tens) * 10 + int'(t.ones));
                end
            end
        end
    end

    initial begin
        bit hit;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        idle(50);

        step(0, 0, 0, 1);
        idle(120);

        hit = 1'b0;
        for (int i = 0; i < DIV + 2; i++) begin
            step(0, 0, 0, 0);
            if (m_tick) begin
                hit = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!hit) begin
            n_bad++;
            $display("FAIL wait_tick: got no tick, expected one within %0d", DIV + 2);
        end
        idle(4);
        step(0, 0, 1, 0);
        idle(30);
        step(0, 0, 0, 1);
        idle(12);

        for (int i = 0; i < DIV + 1; i++) begin
            if (phase == DIV - 1) break;
            step(0, 0, 0, 0);
        end
        step(0, 0, 1, 0);
        idle(5);
        step(0, 0, 0, 1);
        idle(3);

        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        idle((MAXS + 1) * DIV + 15);
        step(0, 0, 0, 1);
        idle(DIV + 2);
        step(0, 1, 0, 0);
        idle(3);

        step(0, 0, 0, 1);
        idle(25);
        step(0, 1, 0, 1);
        idle(3);

        step(0, 0, 0, 1);
        idle(15);
        step(1, 0, 0, 1);
        idle(3);

        for (int i = 0; i < 20000; i++) begin
            step($urandom_range(0, 1999) == 0,
                 $urandom_range(0, 499) == 0,
                 $urandom_range(0, 99) == 0,
                 $urandom_range(0, 19) == 0);
        end

        idle(2);
        @(negedge clk);
        #1;
        chk("tick_q_drain", tick_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
